// File: rtl/fp_result_writeback_pkg.sv
// fp_result_writeback_pkg: shared FP widths, flag indices and writeback entry type.
package fp_result_writeback_pkg;
    localparam int EXP_W = 8;
    localparam int SIG_W = 24;
    localparam int REC_W = 33;
    localparam int MIN_NORM_EXP = 130;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef struct packed {
        logic [REC_W-1:0] rec;
        logic [4:0] flags;
        logic [4:0] rd;
    } wbEntry_t;
endpackage

// File: rtl/fp_result_writeback_rec_fn_to_fn.sv
// rec_fn_to_fn: combinational recoded-F32 to IEEE binary32 conversion.
module rec_fn_to_fn
    import fp_result_writeback_pkg::*;
(
    input  logic [REC_W-1:0]       recIn,
    output logic [EXP_W+SIG_W-1:0] ieeeOut
);
    logic sign, isZero, isSpecial, isNaN, isInf, isSub;
    logic [EXP_W:0] exp;
    logic [SIG_W-2:0] fract, subFract, fractOut;
    logic [4:0] subShift;
    logic [EXP_W-1:0] expOut;
    always_comb begin
        sign = recIn[REC_W-1];
        exp = recIn[REC_W-2:SIG_W-1];
        fract = recIn[SIG_W-2:0];
        isZero = exp[8:6] == 3'b000;
        isSpecial = exp[8:7] == 2'b11;
        isNaN = isSpecial & exp[6];
        isInf = isSpecial & ~exp[6];
        isSub = exp < 9'(MIN_NORM_EXP);
        // only the low 5 bits of the exponent matter: the shift wraps modulo 32
        subShift = 5'd1 - exp[4:0];
        subFract = {~isZero, fract[SIG_W-2:1]} >> subShift;
        expOut = (isNaN | isInf) ? '1 : isSub ? '0 : exp[EXP_W-1:0] - 8'(MIN_NORM_EXP - 1);
        fractOut = isInf ? '0 : isSub ? subFract : fract;
        ieeeOut = {sign, expOut, fractOut};
    end
endmodule

// File: rtl/fp_result_writeback.sv
// fp_result_writeback: 2-entry result FIFO with recoded-to-IEEE conversion and sticky fflags.
module fp_result_writeback
    import fp_result_writeback_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [REC_W-1:0] io_in_out,
    input  logic [4:0]       io_in_exceptionFlags,
    input  logic [4:0]       io_in_rd,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [31:0]      io_out_bits,
    output logic [4:0]       io_out_rd,
    output logic [4:0]       io_out_flags,
    output logic [4:0]       io_fflags,
    input  logic             io_fflagsClear
);
    wbEntry_t mem [2];
    wbEntry_t head;
    logic wrPtr, rdPtr, enq, deq;
    logic [1:0] count;
    always_comb begin
        io_in_ready = count != 2'd2;
        io_out_valid = count != 2'd0;
        enq = io_in_valid & io_in_ready;
        deq = io_out_valid & io_out_ready;
        head = mem[rdPtr];
        io_out_rd = head.rd;
        io_out_flags = head.flags;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= 2'd0;
            io_fflags <= 5'd0;
        end else begin
            wrPtr <= wrPtr ^ enq;
            rdPtr <= rdPtr ^ deq;
            count <= count + {1'b0, enq} - {1'b0, deq};
            io_fflags <= (io_fflagsClear ? 5'd0 : io_fflags) | (deq ? head.flags : 5'd0);
        end
    end
    // payload is qualified by count, so it needs no reset
    always_ff @(posedge clock) begin
        if (enq) mem[wrPtr] <= '{rec: io_in_out, flags: io_in_exceptionFlags, rd: io_in_rd};
    end
    rec_fn_to_fn uConv (
        .recIn(head.rec),
        .ieeeOut(io_out_bits)
    );
endmodule
